// File: rtl/jstk2_pkg.sv
// jstk2_pkg: shared constants and state type for the JSTK2 SPI responder
package jstk2_pkg;
  localparam int PKT_BITS = 40;
  localparam logic [5:0] BYTE4_HDR = 6'b100000;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer with registered rise/fall detection
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  // shift the pin through the chain and flag level changes at its output
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      q_o    <= RST_VAL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      q_o    <= sync_q[STAGES-1];
      rise_o <= sync_q[STAGES-1] & ~q_o;
      fall_o <= ~sync_q[STAGES-1] & q_o;
    end
endmodule

// File: rtl/jstk2_spi_responder.sv
// jstk2_spi_responder: SPI mode-0 slave reporting joystick state; JSTK_RESP_CMD_RX_EN adds command-byte capture
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PKT_BYTES   = PKT_BITS / 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       miso_oe,
  input  logic [9:0] x_val,
  input  logic [9:0] y_val,
  input  logic       jstk_btn,
  input  logic       trig_btn,
  output logic       busy,
  output logic       xfer_done,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid
);
  localparam int NB = PKT_BYTES * 8;
  localparam logic [5:0] NB6 = 6'(NB);
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sig;
  state_t state_q, state_d;
  logic [NB-1:0] sr_q, sr_d;
  logic [5:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic [39:0] pkt;
  logic [NB+39:0] pkt_ext;
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d_i(SCLK), .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .d_i(SS), .q_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d_i(MOSI), .q_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));
  assign unused_sig = ^{sclk_lvl, ss_lvl, mosi_lvl, mosi_rise, mosi_fall};
  assign pkt = {x_val[7:0], 6'b0, x_val[9:8], y_val[7:0], 6'b0, y_val[9:8], BYTE4_HDR, trig_btn, jstk_btn};
  assign pkt_ext = {pkt, {NB{1'b0}}};
  assign MISO = sr_q[NB-1];
  assign busy = (state_q != IDLE);
  assign miso_oe = busy;
  assign xfer_done = done_q;
  // transfer sequencing: snapshot on select, shift on SCLK falls, SS rise always wins
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = SHIFT;
        sr_d    = pkt_ext[NB+39 -: NB];
        cnt_d   = '0;
      end
    end else if (ss_rise) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
      done_d  = (cnt_q == NB6);
    end else begin
      cnt_d = (sclk_rise && cnt_q != NB6) ? cnt_q + 6'd1 : cnt_q;
      if (sclk_fall && state_q == SHIFT) begin
        sr_d    = sr_q << 1;
        state_d = (cnt_q == NB6) ? DRAIN : SHIFT;
      end
    end
  end
  // transfer state registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
`ifdef JSTK_RESP_CMD_RX_EN
  logic [6:0] rx_q;
  logic [7:0] cmd_q;
  logic cmd_v_q;
  logic rx_take;
  assign rx_take = (state_q != IDLE) && !ss_rise && sclk_rise && (cnt_q < 6'd8);
  assign cmd_byte = cmd_q;
  assign cmd_valid = cmd_v_q;
  // collect the first MOSI byte and publish it on the 8th rising edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_q    <= '0;
      cmd_q   <= 8'h00;
      cmd_v_q <= 1'b0;
    end else begin
      cmd_v_q <= rx_take && (cnt_q == 6'd7);
      if (rx_take) rx_q <= {rx_q[5:0], mosi_lvl};
      if (rx_take && cnt_q == 6'd7) cmd_q <= {rx_q, mosi_lvl};
    end
`else
  assign cmd_byte = 8'h00;
  assign cmd_valid = 1'b0;
`endif
endmodule

// File: doc/jstk2_spi_responder.md
JSTK2_SPI_RESPONDER -- requirements
Module: jstk2_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops on SCLK, SS and MOSI (minimum 2).
REQ-002 Parameter PKT_BYTES, default 5: bytes per transaction.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 SCLK  input  1  SPI clock from the master, asynchronous to clk.
REQ-006 SS  input  1  active-low slave select from the master, asynchronous.
REQ-007 MOSI  input  1  command data from the master, asynchronous.
REQ-008 MISO  output  1  serial response data, MSB first.
REQ-009 miso_oe  output  1  high while the block is selected, for the pad tri-state.
REQ-010 x_val, y_val  input  10 each  joystick positions to report.
REQ-011 jstk_btn, trig_btn  input  1 each  button states to report.
REQ-012 busy  output  1  high from SS-fall detection to SS-rise detection.
REQ-013 xfer_done  output  1  one-cycle pulse when a complete packet has been sent.
REQ-014 cmd_byte  output  8  first byte received on MOSI.
REQ-015 cmd_valid  output  1  one-cycle pulse qualifying cmd_byte.

Function
REQ-016 SPI mode 0: MISO changes after synchronized SCLK falling edges; MOSI is sampled on synchronized SCLK rising edges.
REQ-017 Edge detection latency is SYNC_STAGES+1 clk cycles from the pin; SCLK high and low phases shall each be at least 2*(SYNC_STAGES+1) clk cycles.
REQ-018 Packet, byte 0 first: X[7:0]; {6'b0,X[9:8]}; Y[7:0]; {6'b0,Y[9:8]}; {6'b100000,trig_btn,jstk_btn}.
REQ-019 On the detected SS fall, all report inputs are snapshotted into a PKT_BYTES*8-bit shift register, and its MSB drives MISO in the same cycle.
REQ-020 States: IDLE (SS high), SHIFT (SS low, bit count below PKT_BYTES*8), DRAIN (SS low, all bits sent).
REQ-021 Transitions: IDLE->SHIFT on SS fall; SHIFT->DRAIN after falling edge number PKT_BYTES*8; SHIFT/DRAIN->IDLE on SS rise.
REQ-022 Each SCLK fall in SHIFT shifts left by one and inserts zeros; in DRAIN, MISO holds 0.
REQ-023 The bit counter is 6 bits, counts received rising edges, and saturates at PKT_BYTES*8 with no wrap.
REQ-024 xfer_done pulses on the SS-rise cycle only if the counter equals PKT_BYTES*8; an aborted transfer gives no pulse.
REQ-025 cmd_byte latches after the 8th rising edge, and cmd_valid pulses in that same cycle.
REQ-026 A transfer ending before 8 rising edges leaves cmd_byte unchanged and gives no cmd_valid.
REQ-027 SS rise and an SCLK edge detected in the same cycle: SS rise wins and the edge is ignored.
REQ-028 SCLK edges while in IDLE are ignored.
REQ-029 Report inputs may change mid-transfer without affecting the packet in flight.

Reset
REQ-030 Asserting rst at any time, including mid-transfer, shall force IDLE.
REQ-031 Reset values: MISO=0, miso_oe=0, busy=0, xfer_done=0, cmd_valid=0, cmd_byte=8'h00, counter=0, shift register=0.
REQ-032 Synchronizer flops reset to their idle levels: SS=1, SCLK=0, MOSI=0.
REQ-033 After reset release, a transfer starts only on a fresh SS fall.

Configuration
REQ-034 Macro JSTK_RESP_CMD_RX_EN: when defined, the MOSI sampling, cmd_byte and cmd_valid logic is compiled in.
REQ-035 Without JSTK_RESP_CMD_RX_EN: MOSI is ignored, cmd_byte is tied to 8'h00 and cmd_valid to 0, and all ports remain present.

Structure
REQ-036 Package jstk2_pkg shall hold the PKT_BITS constant (40), the byte-4 header constant 6'b100000, and the state enum {IDLE, SHIFT, DRAIN}.
REQ-037 Sub-module spi_edge_sync handles synchronization plus rise/fall detection for one signal, instantiated three times.

Verification
REQ-038 Bench test 1: x=10'h2A5, y=10'h13C, trig=1, jstk=0, full 40-bit transfer -> MISO bytes A5,02,3C,01,82, then one xfer_done pulse.
REQ-039 Bench test 2: command transfer with MOSI=8'hC0 in the first byte (macro defined) -> cmd_byte=C0 with one cmd_valid pulse at the 8th rising edge.
REQ-040 Bench test 3: SS raised after 12 bits -> no xfer_done, busy low, and the next transfer starts again at byte 0.
REQ-041 Bench test 4: 48 SCLK cycles with SS held low -> bits 41-48 on MISO are 0 and exactly one xfer_done pulse.
REQ-042 Bench test 5: x_val changed at bit 5 of a transfer -> the packet carries the snapshot value, and the next transfer carries the new value.
REQ-043 Bench test 6: rst asserted at bit 20 -> all outputs at reset values; after release, a full transfer is correct.
